// File: rtl/controller_spi_rx.sv
// Receive-only SPI front end: synchronises raw pins, deserialises MSB-first bytes, frames 3-byte packets.
// Latency: raw clock high sampled at edge k -> byte_valid/packet_valid high after edge k+SYNC_STAGES+1.
// Backpressure: none; fields are held registers qualified by one-cycle strobes.
module controller_spi_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       chip_data_raw,
  input  logic       chip_clk_raw,
  output logic [7:0] buttons,
  output logic [7:0] joystick_x,
  output logic [7:0] joystick_y,
  output logic       packet_valid,
  output logic [7:0] last_raw_byte,
  output logic       byte_valid,
  output logic [7:0] frame_error_count,
  output logic       link_active
);

  localparam int            IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TO = IW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   prev_clk_q;
  logic                   sync_clk, sync_data, rise;

  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    slot0_q, slot0_d, slot1_q, slot1_d, slot2_q, slot2_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    err_q, err_d;
  logic          byte_done_q, byte_done_d;
  logic          pkt_done_q, pkt_done_d;
  logic          link_active_q;

  logic [7:0] buttons_q, joy_x_q, joy_y_q, last_byte_q;
  logic       byte_valid_q, packet_valid_q;
  logic [7:0] byte_w;

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign rise      = sync_clk & ~prev_clk_q;
  assign byte_w    = {shift_q[6:0], sync_data};

  // Identical synchroniser chains keep data aligned with the clock, plus one flop of clock history
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      prev_clk_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], chip_clk_raw};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], chip_data_raw};
      prev_clk_q  <= sync_clk;
    end
  end

  // Next-state: timeout abort is resolved first so a coincident rise starts a fresh frame
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    slot2_d     = slot2_q;
    idle_cnt_d  = idle_cnt_q;
    err_d       = err_q;
    byte_done_d = 1'b0;
    pkt_done_d  = 1'b0;

    if ((idle_cnt_q == TO) && ((bit_cnt_q != 3'd0) || (byte_idx_q != 2'd0))) begin
      bit_cnt_d  = 3'd0;
      byte_idx_d = 2'd0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    if (rise) begin
      idle_cnt_d = '0;
      shift_d    = byte_w;
      if (bit_cnt_d == 3'd7) begin
        byte_done_d = 1'b1;
        case (byte_idx_d)
          2'd0:    slot0_d = byte_w;
          2'd1:    slot1_d = byte_w;
          default: slot2_d = byte_w;
        endcase
        if (byte_idx_d == 2'd2) begin
          pkt_done_d = 1'b1;
          byte_idx_d = 2'd0;
        end else begin
          byte_idx_d = byte_idx_d + 2'd1;
        end
      end
      bit_cnt_d = bit_cnt_d + 3'd1;
    end else if (idle_cnt_q != TO) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Framing state, idle tracking and error count
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_idx_q    <= '0;
      slot0_q       <= '0;
      slot1_q       <= '0;
      slot2_q       <= '0;
      idle_cnt_q    <= TO;
      err_q         <= '0;
      byte_done_q   <= 1'b0;
      pkt_done_q    <= 1'b0;
      link_active_q <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_idx_q    <= byte_idx_d;
      slot0_q       <= slot0_d;
      slot1_q       <= slot1_d;
      slot2_q       <= slot2_d;
      idle_cnt_q    <= idle_cnt_d;
      err_q         <= err_d;
      byte_done_q   <= byte_done_d;
      pkt_done_q    <= pkt_done_d;
      link_active_q <= (idle_cnt_d < TO);
    end
  end

  // Publish completed bytes and whole packets one cycle after completion, with single-cycle strobes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_byte_q    <= '0;
      byte_valid_q   <= 1'b0;
      buttons_q      <= '0;
      joy_x_q        <= '0;
      joy_y_q        <= '0;
      packet_valid_q <= 1'b0;
    end else begin
      byte_valid_q   <= byte_done_q;
      packet_valid_q <= pkt_done_q;
      if (byte_done_q) last_byte_q <= shift_q;
      if (pkt_done_q) begin
        buttons_q <= slot0_q;
        joy_x_q   <= slot1_q;
        joy_y_q   <= slot2_q;
      end
    end
  end

  assign buttons           = buttons_q;
  assign joystick_x        = joy_x_q;
  assign joystick_y        = joy_y_q;
  assign packet_valid      = packet_valid_q;
  assign last_raw_byte     = last_byte_q;
  assign byte_valid        = byte_valid_q;
  assign frame_error_count = err_q;
  assign link_active       = link_active_q;

endmodule
